// File: rtl/uart_cmd_decoder_if.sv
// Byte-link bundle between UART rx/tx, command decoder and controller.
// The decoder takes the slave side; the controller/harness drives master.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cmd;
  logic [7:0] cmd_arg;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] err_count;

  modport master (
    output rx_data, rx_valid, cmd_ready, tx_ready,
    input  cmd, cmd_arg, cmd_valid, tx_data, tx_valid, err_count
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready, tx_ready,
    output cmd, cmd_arg, cmd_valid, tx_data, tx_valid, err_count
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Frames header/cmd/arg/checksum bytes into commands for the controller
// and answers each complete frame with an ACK or NAK byte.
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15,
  parameter logic [7:0]  MAX_CMD  = 8'h04,
  parameter logic [29:0] TIMEOUT  = 30'd10000000
) (
  input  logic clk,
  input  logic reset,
  uart_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_ARG, GET_CHK,
    DELIVER, SEND_ACK, SEND_NAK
  } state_t;

  state_t      state, state_n;
  logic [29:0] timer, timer_n;
  logic [7:0]  f_cmd, f_arg;
  logic [7:0]  cmd_r, arg_r, tx_r, err_r;
  logic        cmd_v, tx_v;

  logic in_frame, time_out, chk_ok, legal;
  logic ld_cmd, ld_arg, go_dlv, go_ack, go_nak;
  logic tx_done, err_ev;

  assign in_frame = (state == GET_CMD) ||
                    (state == GET_ARG) ||
                    (state == GET_CHK);
  assign time_out = in_frame && !bus.rx_valid &&
                    (timer == TIMEOUT);
  assign chk_ok   = bus.rx_data == (f_cmd ^ f_arg);
  assign legal    = (f_cmd != 8'd0) && (f_cmd <= MAX_CMD);

  // Next state, byte-timer value and per-cycle register load strobes
  always_comb begin
    state_n = state;
    timer_n = 30'd0;
    ld_cmd  = 1'b0;
    ld_arg  = 1'b0;
    go_dlv  = 1'b0;
    go_ack  = 1'b0;
    go_nak  = 1'b0;
    tx_done = 1'b0;
    err_ev  = 1'b0;
    if (in_frame && !bus.rx_valid && !time_out)
      timer_n = timer + 30'd1;
    if (time_out) begin
      state_n = IDLE;
      err_ev  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rx_valid && bus.rx_data == HEADER)
            state_n = GET_CMD;
        end
        GET_CMD: begin
          if (bus.rx_valid) begin
            ld_cmd  = 1'b1;
            state_n = GET_ARG;
          end
        end
        GET_ARG: begin
          if (bus.rx_valid) begin
            ld_arg  = 1'b1;
            state_n = GET_CHK;
          end
        end
        GET_CHK: begin
          if (bus.rx_valid) begin
            if (chk_ok && legal) begin
              go_dlv  = 1'b1;
              state_n = DELIVER;
            end else begin
              go_nak  = 1'b1;
              err_ev  = 1'b1;
              state_n = SEND_NAK;
            end
          end
        end
        DELIVER: begin
          err_ev = bus.rx_valid;
          if (cmd_v && bus.cmd_ready) begin
            go_ack  = 1'b1;
            state_n = SEND_ACK;
          end
        end
        SEND_ACK, SEND_NAK: begin
          err_ev = bus.rx_valid;
          if (tx_v && bus.tx_ready) begin
            tx_done = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, timer, frame buffer and handshake output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= 30'd0;
      f_cmd <= 8'd0;
      f_arg <= 8'd0;
      cmd_r <= 8'd0;
      arg_r <= 8'd0;
      cmd_v <= 1'b0;
      tx_r  <= 8'd0;
      tx_v  <= 1'b0;
      err_r <= 8'd0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (ld_cmd) f_cmd <= bus.rx_data;
      if (ld_arg) f_arg <= bus.rx_data;
      if (go_dlv) begin
        cmd_r <= f_cmd;
        arg_r <= f_arg;
        cmd_v <= 1'b1;
      end else if (go_ack) begin
        cmd_v <= 1'b0;
      end
      if (go_ack) begin
        tx_r <= ACK_BYTE;
        tx_v <= 1'b1;
      end else if (go_nak) begin
        tx_r <= NAK_BYTE;
        tx_v <= 1'b1;
      end else if (tx_done) begin
        tx_v <= 1'b0;
      end
      if (err_ev && err_r != 8'hFF)
        err_r <= err_r + 8'd1;
    end
  end

  assign bus.cmd       = cmd_r;
  assign bus.cmd_arg   = arg_r;
  assign bus.cmd_valid = cmd_v;
  assign bus.tx_data   = tx_r;
  assign bus.tx_valid  = tx_v;
  assign bus.err_count = err_r;

endmodule
